alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit `alu`. Each requester submits an operation (A, B, OP) through a valid/ready handshake. The block grants the ALU round-robin, latches the operands, and drives the ALU from registers. It then captures result and flags into a response register, which it holds until the granted requester accepts it. It sits between the decode/execute front ends and the single combinational ALU instance.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu.sv | 60 ++++++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcodes, flag bit positions, arbiter FSM encoding.
// Pure declarations, no logic.
package alu_pkg;
    localparam int DATA_W = 8;
    localparam int FLG_W  = 5;

    localparam logic [2:0] ALU_ADD        = 3'b000;
    localparam logic [2:0] ALU_SUB        = 3'b001;
    localparam logic [2:0] ALU_AND        = 3'b010;
    localparam logic [2:0] ALU_OR         = 3'b011;
    localparam logic [2:0] ALU_XOR        = 3'b100;
    localparam logic [2:0] ALU_SHL        = 3'b101;
    localparam logic [2:0] ALU_SHR        = 3'b110;
    localparam logic [2:0] ALU_OP_ILLEGAL = 3'b111;

    localparam int FLG_ZRO = 0;
    localparam int FLG_NEG = 1;
    localparam int FLG_SO  = 2;
    localparam int FLG_CO  = 3;
    localparam int FLG_OVR = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: two request channels, two response
// channels sharing one result bus. master = requesters, slave = arbiter.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic                req0_valid, req0_ready;
    logic [DATA_W-1:0]   req0_a, req0_b;
    logic [2:0]          req0_op;
    logic                req1_valid, req1_ready;
    logic [DATA_W-1:0]   req1_a, req1_b;
    logic [2:0]          req1_op;
    logic                rsp0_valid, rsp0_ready;
    logic                rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0]   rsp_y;
    logic [FLG_W-1:0]    rsp_flags;
    logic                rsp_err;
    logic                busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_y, rsp_flags, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_y, rsp_flags, rsp_err, busy
    );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU with {OVR,CO,SO,NEG,ZRO} flags and a hex 7-segment view of y[3:0].
// Zero latency, no handshake.
module alu
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       op,
    output logic [W-1:0]     y,
    output logic [FLG_W-1:0] flags,
    output logic [6:0]       seg
);
    logic [W:0] wide;
    logic       ovr;

    always_comb begin
        wide = '0;
        ovr  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                ovr  = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                ovr  = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
            end
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            ALU_SHL: wide = {a, 1'b0};
            ALU_SHR: wide = {a[0], 1'b0, a[W-1:1]};
            default: wide = '0;
        endcase
        y              = wide[W-1:0];
        flags          = '0;
        flags[FLG_ZRO] = (y == '0);
        flags[FLG_NEG] = y[W-1];
        // SO is the sign of the exact result, i.e. NEG corrected by overflow
        flags[FLG_SO]  = y[W-1] ^ ovr;
        flags[FLG_CO]  = wide[W];
        flags[FLG_OVR] = ovr;
    end

    always_comb begin
        seg = 7'h00;
        case (y[3:0])
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for the shared ALU: handshake t, execute t+1, response held from t+2.
// One op in flight; requests stall (ready low) outside IDLE, response held until its requester takes it.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    arb_state_t        state, state_nxt;
    logic              last;
    logic              grant_vld, grant_id;
    logic              rsp_fire;
    logic [DATA_W-1:0] lat_a, lat_b;
    logic [2:0]        lat_op;
    logic              lat_id;
    logic [DATA_W-1:0] alu_y;
    logic [FLG_W-1:0]  alu_flags;
    logic [DATA_W-1:0] rsp_y_q;
    logic [FLG_W-1:0]  rsp_flags_q;
    logic              rsp_err_q;

    // On a tie the requester not served last wins; otherwise the sole valid one.
    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = ~last;
        else
            grant_id = bus.req1_valid;
    end

    assign bus.req0_ready = !rst && (state == ST_IDLE) && grant_vld && !grant_id;
    assign bus.req1_ready = !rst && (state == ST_IDLE) && grant_vld &&  grant_id;
    assign rsp_fire       = (state == ST_RESP) && (lat_id ? bus.rsp1_ready : bus.rsp0_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_vld) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last        <= 1'b1;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_op      <= '0;
            lat_id      <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && grant_vld) begin
                lat_a  <= grant_id ? bus.req1_a  : bus.req0_a;
                lat_b  <= grant_id ? bus.req1_b  : bus.req0_b;
                lat_op <= grant_id ? bus.req1_op : bus.req0_op;
                lat_id <= grant_id;
                last   <= grant_id;
            end
            if (state == ST_EXEC) begin
                if (lat_op == ALU_OP_ILLEGAL) begin
                    rsp_y_q     <= '0;
                    rsp_flags_q <= '0;
                    rsp_err_q   <= 1'b1;
                end else begin
                    rsp_y_q     <= alu_y;
                    rsp_flags_q <= alu_flags;
                    rsp_err_q   <= 1'b0;
                end
            end
        end
    end

    alu #(.W(DATA_W)) u_alu (
        .a     (lat_a),
        .b     (lat_b),
        .op    (lat_op),
        .y     (alu_y),
        .flags (alu_flags),
        .seg   ()
    );

    assign bus.rsp0_valid = (state == ST_RESP) && !lat_id;
    assign bus.rsp1_valid = (state == ST_RESP) &&  lat_id;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter; a transaction-level model predicts grants,
// response timing and results, and a negedge process compares the DUT against it every cycle.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; } op_t;
    typedef struct { int id; logic [7:0] y; logic [4:0] f; logic e; int hs; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus();
    alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int   cyc = 0;
    int   errors = 0, checks = 0;
    op_t  q0[$], q1[$];
    rsp_t log_q[$];
    int   gap_pct = 0, rdy_pct = 100;
    bit   fire0 = 0, fire1 = 0;

    bit         m_pend = 0, m_after_rst = 0;
    int         m_last = 1, m_id = 0, m_hs = 0;
    logic [7:0] m_y;
    logic [4:0] m_f;
    logic       m_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result computed with plain integer arithmetic.
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                   output logic [7:0] y, output logic [4:0] f, output logic e);
        int ua = a, ub = b;
        int sa = (ua > 127) ? ua - 256 : ua;
        int sb = (ub > 127) ? ub - 256 : ub;
        int r = 0, sr = 0;
        bit co = 0, ovr = 0, so, known = 1, arith = 0;
        case (op)
            3'd0: begin r = ua + ub; sr = sa + sb; co = (r > 255); arith = 1; end
            3'd1: begin r = ua - ub; sr = sa - sb; co = (ua < ub); arith = 1; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * 2; co = (ua >= 128); end
            3'd6: begin r = ua / 2; co = (ua % 2 == 1); end
            default: known = 0;
        endcase
        y = known ? 8'(r & 255) : 8'h00;
        if (arith) begin
            ovr = (sr > 127) || (sr < -128);
            so  = (sr < 0);
        end else begin
            so  = (y >= 128);
        end
        f = known ? {ovr, co, so, (y >= 128), (y == 0)} : 5'b0;
        e = !known;
    endfunction

    always @(negedge clk) begin
        int w;
        fire0 = 0;
        fire1 = 0;
        if (rst) begin
            chk(bus.req0_ready == 0 && bus.req1_ready == 0, "rst_ready",
                {bus.req1_ready, bus.req0_ready}, 0);
            m_pend = 0;
            m_last = 1;
            m_after_rst = 1;
        end else begin
            if (m_after_rst) begin
                chk(bus.rsp_y == 0 && bus.rsp_flags == 0 && bus.rsp_err == 0, "rst_rsp",
                    {bus.rsp_y, bus.rsp_flags, bus.rsp_err}, 0);
                m_after_rst = 0;
            end
            if (!m_pend) begin
                w = -1;
                if (bus.req0_valid && bus.req1_valid) w = (m_last == 1) ? 0 : 1;
                else if (bus.req0_valid) w = 0;
                else if (bus.req1_valid) w = 1;
                chk({bus.busy, bus.rsp1_valid, bus.rsp0_valid} == 3'b000, "idle_ctl",
                    {bus.busy, bus.rsp1_valid, bus.rsp0_valid}, 0);
                chk(bus.req0_ready == (w == 0) && bus.req1_ready == (w == 1), "grant",
                    {bus.req1_ready, bus.req0_ready}, {(w == 1), (w == 0)});
                if (w == 0) begin ref_op(bus.req0_a, bus.req0_b, bus.req0_op, m_y, m_f, m_e); fire0 = 1; end
                if (w == 1) begin ref_op(bus.req1_a, bus.req1_b, bus.req1_op, m_y, m_f, m_e); fire1 = 1; end
                if (w >= 0) begin m_pend = 1; m_id = w; m_hs = cyc; m_last = w; end
            end else if (cyc - m_hs == 1) begin
                chk({bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid} == 5'b10000,
                    "exec_ctl", {bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid}, 5'b10000);
            end else begin
                chk({bus.busy, bus.req1_ready, bus.req0_ready} == 3'b100, "resp_ctl",
                    {bus.busy, bus.req1_ready, bus.req0_ready}, 3'b100);
                chk(bus.rsp0_valid == (m_id == 0) && bus.rsp1_valid == (m_id == 1), "rsp_valid",
                    {bus.rsp1_valid, bus.rsp0_valid}, {(m_id == 1), (m_id == 0)});
                chk(bus.rsp_y == m_y, "rsp_y", bus.rsp_y, m_y);
                chk(bus.rsp_flags == m_f, "rsp_flags", bus.rsp_flags, m_f);
                chk(bus.rsp_err == m_e, "rsp_err", bus.rsp_err, m_e);
                if ((m_id == 0 && bus.rsp0_ready) || (m_id == 1 && bus.rsp1_ready)) begin
                    log_q.push_back('{m_id, m_y, m_f, m_e, m_hs});
                    m_pend = 0;
                end
            end
        end
    end

    // Requesters hold valid and payload until the handshake seen at the previous negedge.
    initial begin
        op_t o;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (fire0) bus.req0_valid = 0;
            if (fire1) bus.req1_valid = 0;
            if (!bus.req0_valid && q0.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                o = q0.pop_front();
                bus.req0_a = o.a; bus.req0_b = o.b; bus.req0_op = o.op; bus.req0_valid = 1;
            end
            if (!bus.req1_valid && q1.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                o = q1.pop_front();
                bus.req1_a = o.a; bus.req1_b = o.b; bus.req1_op = o.op; bus.req1_valid = 1;
            end
            bus.rsp0_ready = ($urandom_range(0, 99) < rdy_pct);
            bus.rsp1_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (n < budget && !(q0.size() == 0 && q1.size() == 0 &&
                               !bus.req0_valid && !bus.req1_valid && !m_pend)) begin
            @(posedge clk);
            n++;
        end
        chk(n < budget, name, n, budget);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic expect_rsp(input int idx, input int id, input int y, input int fmask,
                              input int fval, input bit e, input string name);
        if (idx >= log_q.size()) begin
            chk(0, {name, "_missing"}, log_q.size(), idx + 1);
        end else begin
            chk(log_q[idx].id == id, {name, "_id"}, log_q[idx].id, id);
            chk(log_q[idx].y == y, {name, "_y"}, log_q[idx].y, y);
            chk((log_q[idx].f & fmask) == fval, {name, "_flags"}, log_q[idx].f, fval);
            chk(log_q[idx].e == e, {name, "_err"}, log_q[idx].e, e);
        end
    endtask

    task automatic wait_valid(input int id, output logic [7:0] y);
        bit seen = 0;
        y = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if ((id == 0 && bus.rsp0_valid) || (id == 1 && bus.rsp1_valid)) begin
                seen = 1;
                y = bus.rsp_y;
            end
        end
        chk(seen, "wait_rsp_valid", seen, 1);
    endtask

    initial begin
        int base;
        logic [7:0] held_y;
        op_t o;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk({bus.busy, bus.rsp1_valid, bus.rsp0_valid} == 3'b000, "reset_ctl",
            {bus.busy, bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk(bus.rsp_y == 8'h00 && bus.rsp_flags == 5'h00, "reset_data", {bus.rsp_y, bus.rsp_flags}, 0);

        // single requester
        base = log_q.size();
        q0.push_back('{8'hD0, 8'h75, ALU_ADD});
        drain(100, "t1_drain");
        expect_rsp(base, 0, 'h45, 5'b01001, 5'b01000, 0, "t1");

        // tie after reset, then next tie
        do_reset();
        base = log_q.size();
        q0.push_back('{8'h29, 8'h55, ALU_ADD});
        q1.push_back('{8'hF5, 8'hAB, ALU_ADD});
        drain(100, "t2_drain");
        expect_rsp(base, 0, 'h7E, 5'b10000, 5'b00000, 0, "t2_first");
        expect_rsp(base + 1, 1, 'hA0, 5'b01010, 5'b01010, 0, "t2_second");
        q0.push_back('{8'h01, 8'h02, ALU_ADD});
        q1.push_back('{8'h03, 8'h04, ALU_ADD});
        drain(100, "t2b_drain");
        expect_rsp(base + 2, 0, 'h03, 0, 0, 0, "t2_retie0");
        expect_rsp(base + 3, 1, 'h07, 0, 0, 0, "t2_retie1");

        // response backpressure
        rdy_pct = 0;
        base = log_q.size();
        q1.push_back('{8'h10, 8'h20, ALU_ADD});
        wait_valid(1, held_y);
        q0.push_back('{8'h07, 8'h03, ALU_SUB});
        repeat (5) begin
            @(negedge clk);
            chk({bus.rsp1_valid, bus.busy, bus.req0_ready} == 3'b110, "bp_hold",
                {bus.rsp1_valid, bus.busy, bus.req0_ready}, 3'b110);
            chk(bus.rsp_y == held_y, "bp_data", bus.rsp_y, held_y);
        end
        rdy_pct = 100;
        @(negedge clk);
        @(negedge clk);
        chk({bus.busy, bus.req0_ready} == 2'b01, "bp_release", {bus.busy, bus.req0_ready}, 2'b01);
        drain(100, "t3_drain");
        expect_rsp(base, 1, 'h30, 0, 0, 0, "t3_bp");
        expect_rsp(base + 1, 0, 'h04, 5'b01000, 5'b00000, 0, "t3_after");

        // illegal opcode
        base = log_q.size();
        q1.push_back('{8'h12, 8'h34, ALU_OP_ILLEGAL});
        drain(100, "t4_drain");
        expect_rsp(base, 1, 'h00, 5'h1F, 5'h00, 1, "t4_illegal");

        // reset while a response is held
        rdy_pct = 0;
        q0.push_back('{8'h05, 8'h06, ALU_ADD});
        wait_valid(0, held_y);
        do_reset();
        @(negedge clk);
        chk({bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err} == 4'b0000, "t5_rst_ctl",
            {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err}, 0);
        chk(bus.rsp_y == 8'h00 && bus.rsp_flags == 5'h00, "t5_rst_data", {bus.rsp_y, bus.rsp_flags}, 0);
        rdy_pct = 100;
        base = log_q.size();
        q0.push_back('{8'h80, 8'h80, ALU_ADD});
        q1.push_back('{8'h0F, 8'hF0, ALU_OR});
        drain(100, "t5_drain");
        expect_rsp(base, 0, 'h00, 5'b11001, 5'b11001, 0, "t5_tie0");
        expect_rsp(base + 1, 1, 'hFF, 0, 0, 0, "t5_tie1");

        // both requesters continuously valid
        base = log_q.size();
        for (int i = 0; i < 6; i++) begin
            o = '{8'($urandom), 8'($urandom), 3'($urandom_range(0, 7))};
            q0.push_back(o);
            o = '{8'($urandom), 8'($urandom), 3'($urandom_range(0, 7))};
            q1.push_back(o);
        end
        drain(200, "t6_drain");
        chk(log_q.size() == base + 12, "t6_count", log_q.size() - base, 12);
        for (int i = 1; i < 12; i++) begin
            if (base + i < log_q.size()) begin
                chk(log_q[base + i].id != log_q[base + i - 1].id, "t6_alternate",
                    log_q[base + i].id, 1 - log_q[base + i - 1].id);
                chk(log_q[base + i].hs - log_q[base + i - 1].hs == 3, "t6_spacing",
                    log_q[base + i].hs - log_q[base + i - 1].hs, 3);
            end
        end

        // random traffic with gaps and response backpressure
        gap_pct = 40;
        rdy_pct = 60;
        base = log_q.size();
        for (int i = 0; i < 80; i++) begin
            o = '{8'($urandom), 8'($urandom), 3'($urandom_range(0, 7))};
            q0.push_back(o);
            o = '{8'($urandom), 8'($urandom), 3'($urandom_range(0, 7))};
            q1.push_back(o);
        end
        drain(6000, "rand_drain");
        chk(log_q.size() == base + 160, "rand_count", log_q.size() - base, 160);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
